regfile_rtype_sequencer: RTL and testbench

- Multi-cycle client of the 32x32 register file. Accepts one MIPS R-type instruction word per valid/ready handshake.
- Drives the register file's two read addresses and latches the operands. Computes the result with an internal ALU, then drives one write-back through the file's write port.
- Sits between the instruction source (test harness, later the fetch stage) and the register file. Provides the write side and the read-request side of that interface.

---
 rtl/regfile_rtype_sequencer_pkg.sv | 45 ++++
 rtl/regfile_rtype_sequencer_alu.sv | 58 +++++
 rtl/regfile_rtype_sequencer.sv | 136 +++++++++++++
 tb/tb_regfile_rtype_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rtype_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rtype_sequencer_pkg
// Description : Shared opcode/funct codes, instruction field positions and
//               the sequencer state type for the R-type register-file client.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_rtype_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_rtype_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : rtype_alu
// Description : Combinational R-type ALU: result, signed overflow on add/sub,
//               and an illegal flag for unsupported funct codes.
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_alu
  import regfile_rtype_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o,
  output logic              illegal_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;

  assign w_sum  = op_a_i + op_b_i;
  assign w_diff = op_a_i - op_b_i;

  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (funct_i)
      FUNCT_ADD: begin
        result_o = w_sum;
        ovf_o    = (op_a_i[MSB] == op_b_i[MSB]) && (w_sum[MSB] != op_a_i[MSB]);
      end
      FUNCT_SUB: begin
        result_o = w_diff;
        // A-B overflows only when the operand signs differ
        ovf_o    = (op_a_i[MSB] != op_b_i[MSB]) && (w_diff[MSB] != op_a_i[MSB]);
      end
      FUNCT_AND:  result_o = op_a_i & op_b_i;
      FUNCT_OR:   result_o = op_a_i | op_b_i;
      FUNCT_XOR:  result_o = op_a_i ^ op_b_i;
      FUNCT_NOR:  result_o = ~(op_a_i | op_b_i);
      FUNCT_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      FUNCT_SLTU: result_o = {{(DATA_W-1){1'b0}}, (op_a_i < op_b_i)};
      FUNCT_SLL:  result_o = op_b_i << shamt_i;
      FUNCT_SRL:  result_o = op_b_i >> shamt_i;
      FUNCT_SRA:  result_o = $unsigned($signed(op_b_i) >>> shamt_i);
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regfile_rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rtype_sequencer
// Description : Accepts one R-type instruction per handshake, reads rs/rt
//               from the register file, executes, and writes rd back.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rtype_sequencer
  import regfile_rtype_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] rg_rd_addr1,
  output logic [ADDR_W-1:0] rg_rd_addr2,
  input  logic [DATA_W-1:0] rg_rd_data1,
  input  logic [DATA_W-1:0] rg_rd_data2,
  output logic              rg_wrt_en,
  output logic [ADDR_W-1:0] rg_wrt_addr,
  output logic [DATA_W-1:0] rg_wrt_data,
  output logic              done,
  output logic              err_illegal,
  output logic              ovf
);

  state_e              state_q;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W-1:0]   result_q;
  logic [ADDR_W-1:0]   wrt_addr_q;
  logic                ready_q;
  logic                wrt_en_q;
  logic                done_q;
  logic                err_q;
  logic                ovf_q;

  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_ovf;
  logic                w_alu_illegal;
  logic                w_illegal;
  logic [ADDR_W-1:0]   w_rd;

  rtype_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_a_i    (op_a_q),
    .op_b_i    (op_b_q),
    .shamt_i   (instr_q[SH_HI:SH_LO]),
    .funct_i   (instr_q[FN_HI:FN_LO]),
    .result_o  (w_alu_result),
    .ovf_o     (w_alu_ovf),
    .illegal_o (w_alu_illegal)
  );

  // Legality depends only on op/funct, so it is already known during READ.
  assign w_illegal = (instr_q[OP_HI:OP_LO] != OP_RTYPE) || w_alu_illegal;
  assign w_rd      = instr_q[RD_HI:RD_LO];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      wrt_addr_q <= '0;
      ready_q    <= 1'b1;
      wrt_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wrt_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            ready_q <= 1'b0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          op_a_q  <= rg_rd_data1;
          op_b_q  <= rg_rd_data2;
          state_q <= ST_EXEC;
          if (w_illegal) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_illegal) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            result_q   <= w_alu_result;
            wrt_addr_q <= w_rd;
            wrt_en_q   <= (w_rd != '0);
            done_q     <= 1'b1;
            ovf_q      <= w_alu_ovf;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rg_rd_addr1 = instr_q[RS_HI:RS_LO];
  assign rg_rd_addr2 = instr_q[RT_HI:RT_LO];
  assign rg_wrt_en   = wrt_en_q;
  assign rg_wrt_addr = wrt_addr_q;
  assign rg_wrt_data = result_q;
  assign done        = done_q;
  assign err_illegal = err_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_rtype_sequencer
// Description : Self-checking bench: vector table, corner sequences, and
//               randomized instructions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_rtype_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rg_rd_addr1;
  logic [4:0]  rg_rd_addr2;
  logic [31:0] rg_rd_data1;
  logic [31:0] rg_rd_data2;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic        done;
  logic        err_illegal;
  logic        ovf;

  logic [31:0] rf [32];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_rtype_sequencer #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rg_rd_addr1 (rg_rd_addr1),
    .rg_rd_addr2 (rg_rd_addr2),
    .rg_rd_data1 (rg_rd_data1),
    .rg_rd_data2 (rg_rd_data2),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .done        (done),
    .err_illegal (err_illegal),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  assign rg_rd_data1 = rf[rg_rd_addr1];
  assign rg_rd_data2 = rf[rg_rd_addr2];

  logic [5:0] legal_fn [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ins;
    logic        legal;
    logic [31:0] data;
    logic        ov;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Behavioural reference: 64-bit arithmetic, overflow judged by range.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, output logic legal,
                                output logic [31:0] res, output logic ov);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint r;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    legal = 1'b1;
    ov    = 1'b0;
    res   = 32'd0;
    r     = 0;
    if (op != 6'd0) begin
      legal = 1'b0;
    end else begin
      case (fn)
        6'h20: begin r = sa + sb; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
        6'h22: begin r = sa - sb; res = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: res = (ua < ub) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: begin r = sb >>> sh; res = r[31:0]; end
        default: legal = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the sequencer idle; returns at the negedge of
  // the first cycle it is ready again, so consecutive calls are back-to-back.
  task automatic run_check(input string tag, input logic [31:0] ins, input logic exp_legal,
                           input logic [31:0] exp_data, input logic exp_ov);
    int          done_cyc;
    int          wen_cyc;
    int          rdy_cyc;
    int          ndone;
    int          nwen;
    logic        got_err;
    logic        got_ov;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    done_cyc = -1; wen_cyc = -1; rdy_cyc = -1; ndone = 0; nwen = 0;
    got_err = 1'b0; got_ov = 1'b0; waddr = '0; wdata = '0; a1 = '0; a2 = '0;
    rd = ins[15:11];
    chk({tag, " ready_idle"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    instr = $urandom;  // valid stays high: a busy sequencer must ignore it
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a1 = rg_rd_addr1;
        a2 = rg_rd_addr2;
      end
      if (done) begin
        ndone++;
        done_cyc = k;
        got_err  = err_illegal;
        got_ov   = ovf;
      end
      if (rg_wrt_en) begin
        nwen++;
        wen_cyc = k;
        waddr   = rg_wrt_addr;
        wdata   = rg_wrt_data;
        if (rg_wrt_addr != 5'd0) rf[rg_wrt_addr] = rg_wrt_data;
      end
      if (instr_ready) begin
        rdy_cyc = k;
        break;
      end
    end
    instr_valid = 1'b0;
    chk({tag, " rd_addr1"}, 32'(a1), 32'(ins[25:21]));
    chk({tag, " rd_addr2"}, 32'(a2), 32'(ins[20:16]));
    chk({tag, " done_count"}, 32'(ndone), 32'd1);
    if (exp_legal) begin
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'd3);
      chk({tag, " err"}, 32'(got_err), 32'd0);
      chk({tag, " ovf"}, 32'(got_ov), 32'(exp_ov));
      chk({tag, " ready_cycle"}, 32'(rdy_cyc), 32'd4);
      if (rd != 5'd0) begin
        chk({tag, " wen_count"}, 32'(nwen), 32'd1);
        chk({tag, " wen_cycle"}, 32'(wen_cyc), 32'd3);
        chk({tag, " waddr"}, 32'(waddr), 32'(rd));
        chk({tag, " wdata"}, wdata, exp_data);
      end else begin
        chk({tag, " wen_count_rd0"}, 32'(nwen), 32'd0);
      end
    end else begin
      chk({tag, " done_cycle_ill"}, 32'(done_cyc), 32'd2);
      chk({tag, " err_ill"}, 32'(got_err), 32'd1);
      chk({tag, " wen_count_ill"}, 32'(nwen), 32'd0);
      chk({tag, " ready_cycle_ill"}, 32'(rdy_cyc), 32'd3);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, 32'(instr_ready), 32'd1);
    chk({tag, " wen"}, 32'(rg_wrt_en), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err_illegal), 32'd0);
    chk({tag, " ovf"}, 32'(ovf), 32'd0);
    chk({tag, " addr1"}, 32'(rg_rd_addr1), 32'd0);
    chk({tag, " addr2"}, 32'(rg_rd_addr2), 32'd0);
    chk({tag, " waddr"}, 32'(rg_wrt_addr), 32'd0);
    chk({tag, " wdata"}, rg_wrt_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;

    vecs[0]  = '{32'd5,        32'd7,        32'h0022_1820,                  1'b1, 32'd12,       1'b0};
    vecs[1]  = '{32'h7FFFFFFF, 32'd1,        rtype(6'h00, 1, 2, 4, 0, 6'h20), 1'b1, 32'h80000000, 1'b1};
    vecs[2]  = '{32'h80000000, 32'd1,        rtype(6'h00, 1, 2, 4, 0, 6'h22), 1'b1, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{32'd0,        32'h80000000, rtype(6'h00, 1, 2, 5, 4, 6'h03), 1'b1, 32'hF8000000, 1'b0};
    vecs[4]  = '{32'd0,        32'h80000000, rtype(6'h00, 1, 2, 5, 4, 6'h02), 1'b1, 32'h08000000, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1,        rtype(6'h00, 1, 2, 6, 0, 6'h2A), 1'b1, 32'd1,        1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1,        rtype(6'h00, 1, 2, 6, 0, 6'h2B), 1'b1, 32'd0,        1'b0};
    vecs[7]  = '{32'hF0F01234, 32'h0FF0FF00, rtype(6'h00, 1, 2, 7, 0, 6'h24), 1'b1, 32'h00F01200, 1'b0};
    vecs[8]  = '{32'hF0F01234, 32'h0FF0FF00, rtype(6'h00, 1, 2, 7, 0, 6'h25), 1'b1, 32'hFFF0FF34, 1'b0};
    vecs[9]  = '{32'hF0F01234, 32'h0FF0FF00, rtype(6'h00, 1, 2, 7, 0, 6'h26), 1'b1, 32'hFF00ED34, 1'b0};
    vecs[10] = '{32'hF0F01234, 32'h0FF0FF00, rtype(6'h00, 1, 2, 7, 0, 6'h27), 1'b1, 32'h000F00CB, 1'b0};
    vecs[11] = '{32'd0,        32'd1,        rtype(6'h00, 1, 2, 8, 31, 6'h00), 1'b1, 32'h80000000, 1'b0};
    vecs[12] = '{32'd5,        32'd7,        rtype(6'h00, 1, 2, 9, 0, 6'h22), 1'b1, 32'hFFFFFFFE, 1'b0};
    vecs[13] = '{32'd5,        32'd7,        rtype(6'h08, 1, 2, 10, 0, 6'h20), 1'b0, 32'd0,       1'b0};
    vecs[14] = '{32'd5,        32'd7,        rtype(6'h00, 1, 2, 10, 0, 6'h3F), 1'b0, 32'd0,       1'b0};
    vecs[15] = '{32'h80000000, 32'h80000000, rtype(6'h00, 1, 2, 11, 0, 6'h20), 1'b1, 32'd0,       1'b1};
    vecs[16] = '{32'd0,        32'h80000000, rtype(6'h00, 1, 2, 11, 0, 6'h22), 1'b1, 32'h80000000, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      rf[1] = vecs[i].a;
      rf[2] = vecs[i].b;
      run_check($sformatf("vec%0d", i), vecs[i].ins, vecs[i].legal, vecs[i].data, vecs[i].ov);
    end

    // rd=0 still retires without a write; then a read-after-write pair.
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    run_check("rd0", rtype(6'h00, 1, 2, 0, 0, 6'h20), 1'b1, 32'd12, 1'b0);
    run_check("r3_write", rtype(6'h00, 1, 2, 3, 0, 6'h20), 1'b1, 32'd12, 1'b0);
    run_check("r3_double", rtype(6'h00, 3, 3, 3, 0, 6'h20), 1'b1, 32'd24, 1'b0);
    chk("r3_model", rf[3], 32'd24);

    // Reset while the instruction sits in EXEC.
    instr_valid = 1'b1;
    instr       = rtype(6'h00, 1, 2, 12, 0, 6'h20);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_exec");
    reset = 1'b0;
    run_check("after_rst", rtype(6'h00, 1, 2, 13, 0, 6'h20), 1'b1, 32'd12, 1'b0);

    // Reset wins over a simultaneous valid.
    begin
      int stray;
      stray       = 0;
      reset       = 1'b1;
      instr_valid = 1'b1;
      instr       = rtype(6'h00, 1, 2, 14, 0, 6'h20);
      @(posedge clk);
      #1;
      reset       = 1'b0;
      instr_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done || rg_wrt_en || !instr_ready) stray++;
      end
      chk("rst_vs_valid", 32'(stray), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [5:0]  op;
      logic        leg;
      logic        ov;
      logic [31:0] res;
      logic [31:0] ins;
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      sh = 5'($urandom_range(0, 31));
      fn = legal_fn[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if (rs != 5'd0) rf[rs] = pick();
      if (rt != 5'd0) rf[rt] = pick();
      ins = rtype(op, rs, rt, rd, sh, fn);
      model(ins, rf[rs], rf[rt], leg, res, ov);
      run_check($sformatf("rnd%0d", i), ins, leg, res, ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
